mmu_banked: RTL and testbench
=============================

Name: mmu_banked

Overview:
- Second-generation memory management unit.
- Decodes the 16-bit CPU bus and adds what the first-generation MMU lacked: MBC1-style ROM/RAM bank switching generalised by parameter, a BIOS-unmap latch at FF50, an OAM DMA engine at FF46, internal HRAM, and PPU-mode access locks.
- Sits between the CPU, the cartridge/external RAM, the VRAM/WRAM/OAM arrays and the GPU register file.

Parameters:
- ROM_BANK_BITS, 7, ROM bank number width; ROM physical address width = 14+ROM_BANK_BITS.
- RAM_BANK_BITS, 2, external RAM bank number width; RAM physical address width = 13+RAM_BANK_BITS.
- DMA_LEN, 160, bytes copied per OAM DMA.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous reset, active-high.
- iCpuAddr  in  16  CPU address.
- iCpuReadRequest  in  1  CPU read strobe.
- iCpuWe  in  1  CPU write strobe.
- iCpuData  in  8  CPU write data.
- oCpuData  out  8  CPU read data, registered.
- oBusAddr  out  16  shared memory address; iCpuAddr when DMA is idle, DMA source otherwise.
- oBusWe  out  1  gated CPU write to VRAM/WRAM/OAM/IO.
- oBusData  out  8  write data (iCpuData).
- iBusData  in  8  read data from synchronous memories, 1-cycle latency.
- oRomAddr  out  14+ROM_BANK_BITS  banked cartridge ROM address.
- oBiosSel  out  1  BIOS overlays ROM for the current address.
- oExtRamAddr  out  13+RAM_BANK_BITS  banked external RAM address.
- oExtRamWe  out  1  external RAM write.
- oOamWe  out  1  DMA write strobe to OAM.
- oOamAddr  out  8  DMA OAM index.
- oOamData  out  8  DMA OAM write data.
- oDmaActive  out  1  DMA in progress.
- iGpuVramLock  in  1  PPU mode 3 and LCD on.
- iGpuOamLock  in  1  PPU mode 2 or 3 and LCD on.

Behaviour:
- Reset values:
  - Bank registers: rom_lo=1, rom_hi=0, mode=0, ram_en=0.
  - bios_off=0; DMA idle.
  - All outputs 0, except oBusAddr = iCpuAddr.
  - HRAM contents are undefined after reset.
- MBC writes (iCpuWe, addr < 8000):
  - 0000-1FFF: ram_en = (data[3:0] == A).
  - 2000-3FFF: rom_lo = data[4:0]; a written 0 becomes 1.
  - 4000-5FFF: rom_hi = data[1:0].
  - 6000-7FFF: mode = data[0].
  - None of these writes reaches oBusWe.
- ROM bank and address:
  - rom_bank = {rom_hi, rom_lo} truncated to ROM_BANK_BITS. The zero-fix applies to rom_lo only, so 20h/40h/60h map to 21h/41h/61h.
  - addr < 4000: oRomAddr = {0, addr[13:0]}.
  - 4000-7FFF: oRomAddr = {rom_bank, addr[13:0]}.
- External RAM bank: ram_bank = mode ? rom_hi : 0, truncated to RAM_BANK_BITS; oExtRamAddr = {ram_bank, addr[12:0]}.
- External RAM access (A000-BFFF):
  - Reads return FF when ram_en=0.
  - oExtRamWe = iCpuWe & ram_en.
- BIOS unmap:
  - oBiosSel = !bios_off & (addr < 0100).
  - A write of a non-zero value to FF50 sets bios_off; it is sticky until reset.
  - Reading FF50 returns {7'h7F, bios_off}.
- HRAM:
  - Internal array of 127 bytes covering FF80-FFFE.
  - Writes take effect on the clock edge.
  - Reads are registered, same latency as iBusData.
- Read latency: oCpuData is valid 1 cycle after the address is presented, for all regions.
- PPU locks:
  - iGpuVramLock: CPU reads of 8000-9FFF return FF; writes are dropped.
  - iGpuOamLock: the same rule applies to FE00-FE9F.
- DMA state machine, IDLE -> RUN -> IDLE:
  - A CPU write of V to FF46 latches src = {V, 00}, stores V (readable at FF46), sets idx=0 and enters RUN on the next edge.
  - RUN cycle n (n < DMA_LEN): oBusAddr = src+n.
  - RUN cycle n+1: oOamWe=1, oOamAddr=n, oOamData=iBusData.
  - After the write of index DMA_LEN-1 the engine returns to IDLE.
  - oDmaActive is high for DMA_LEN+1 cycles, starting the cycle after the FF46 write.
- During RUN:
  - CPU reads outside FF80-FFFE return FF.
  - CPU writes outside FF80-FFFE and FF46 are dropped.
  - A write to FF46 restarts the transfer at idx 0 with the new source; the in-flight write still completes.
- Reset in RUN aborts the transfer immediately: oOamWe=0, state IDLE.

Test Plan:
- Write 00 to 2000, then read 4000 -> oRomAddr = 0x04000 (bank 1).
- Write 05 to 2000 and 02 to 4000 -> oRomAddr at 4123 = {7'h45, 14'h0123}.
- With ram_en=0, write A000 -> oExtRamWe=0 and the read returns FF. Write 0A to 0000, then mode=1 and rom_hi=3 -> oExtRamAddr at A010 = {2'b11, 13'h0010} and the write is accepted.
- Read 0050 -> oBiosSel=1. Write 01 to FF50 -> oBiosSel=0, and FF50 reads FF.
- Write C1 to FF46 -> oDmaActive high for 161 cycles; the OAM receives bytes C100-C19F in order. A CPU read of C000 returns FF during the transfer, while a write/read of FF90 succeeds.
- Assert iReset at DMA idx 80 -> oDmaActive=0 and oOamWe=0 immediately; the next FF46 write restarts at idx 0.

Source files
------------

// File: rtl/mmu_banked.sv
// mmu_banked: CPU bus decoder with MBC1-style banking, BIOS unmap latch, OAM DMA, HRAM and PPU access locks.
module mmu_banked #(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int DMA_LEN       = 160
) (
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic [15:0]                   iCpuAddr,
    input  logic                          iCpuReadRequest,
    input  logic                          iCpuWe,
    input  logic [7:0]                    iCpuData,
    output logic [7:0]                    oCpuData,
    output logic [15:0]                   oBusAddr,
    output logic                          oBusWe,
    output logic [7:0]                    oBusData,
    input  logic [7:0]                    iBusData,
    output logic [14+ROM_BANK_BITS-1:0]   oRomAddr,
    output logic                          oBiosSel,
    output logic [13+RAM_BANK_BITS-1:0]   oExtRamAddr,
    output logic                          oExtRamWe,
    output logic                          oOamWe,
    output logic [7:0]                    oOamAddr,
    output logic [7:0]                    oOamData,
    output logic                          oDmaActive,
    input  logic                          iGpuVramLock,
    input  logic                          iGpuOamLock
);
    localparam logic [7:0] LEN = 8'(DMA_LEN);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [4:0] rom_lo_q, rom_lo_d;
    logic [1:0] rom_hi_q, rom_hi_d;
    logic mode_q, mode_d, ram_en_q, ram_en_d, bios_off_q, bios_off_d;
    logic [7:0] dma_src_q, dma_src_d, cnt_q, cnt_d, wr_idx_q, wr_idx_d;
    logic wr_q, wr_d, rd_bus_q, rd_bus_d;
    logic [7:0] rd_val_q, rd_val_d;
    logic [7:0] hram_q [0:126];
    logic run, is_vram, is_ext, is_oam, is_hram, is_ff46, is_ff50, blocked, cpu_wr;
    logic [15:0] rom_full, ram_full;
    assign run      = state_q == RUN;
    assign is_vram  = iCpuAddr[15:13] == 3'b100;
    assign is_ext   = iCpuAddr[15:13] == 3'b101;
    assign is_oam   = iCpuAddr[15:8] == 8'hFE && iCpuAddr[7:0] < 8'hA0;
    assign is_hram  = iCpuAddr[15:7] == 9'h1FF && iCpuAddr[6:0] != 7'h7F;
    assign is_ff46  = iCpuAddr == 16'hFF46;
    assign is_ff50  = iCpuAddr == 16'hFF50;
    assign blocked  = (is_vram && iGpuVramLock) || (is_oam && iGpuOamLock);
    // While DMA owns the bus only HRAM and the DMA register stay reachable.
    assign cpu_wr   = iCpuWe && (!run || is_hram || is_ff46);
    assign rom_full = {9'd0, rom_hi_q, rom_lo_q};
    assign ram_full = {14'd0, mode_q ? rom_hi_q : 2'd0};
    assign oRomAddr    = {iCpuAddr[15:14] == 2'b01 ? rom_full[ROM_BANK_BITS-1:0] : {ROM_BANK_BITS{1'b0}}, iCpuAddr[13:0]};
    assign oExtRamAddr = {ram_full[RAM_BANK_BITS-1:0], iCpuAddr[12:0]};
    assign oBiosSel    = !bios_off_q && iCpuAddr < 16'h0100;
    assign oBusAddr    = run ? {dma_src_q, 8'h00} + {8'h00, cnt_q} : iCpuAddr;
    assign oBusWe      = iCpuWe && !run && iCpuAddr[15] && !is_ext && !is_hram && !is_ff46 && !is_ff50 && !blocked;
    assign oBusData    = iCpuData;
    assign oExtRamWe   = iCpuWe && !run && is_ext && ram_en_q;
    assign oOamWe      = wr_q;
    assign oOamAddr    = wr_idx_q;
    assign oOamData    = wr_q ? iBusData : 8'h00;
    assign oDmaActive  = run;
    assign oCpuData    = rd_bus_q ? iBusData : rd_val_q;
    always_comb begin
        state_d    = state_q;
        rom_lo_d   = rom_lo_q;
        rom_hi_d   = rom_hi_q;
        mode_d     = mode_q;
        ram_en_d   = ram_en_q;
        bios_off_d = bios_off_q;
        dma_src_d  = dma_src_q;
        cnt_d      = cnt_q;
        wr_d       = run && cnt_q < LEN;
        wr_idx_d   = cnt_q;
        rd_bus_d   = 1'b0;
        rd_val_d   = 8'h00;
        if (cpu_wr && !iCpuAddr[15]) begin
            if (iCpuAddr[14:13] == 2'd0) ram_en_d = iCpuData[3:0] == 4'hA;
            if (iCpuAddr[14:13] == 2'd1) rom_lo_d = iCpuData[4:0] == 5'd0 ? 5'd1 : iCpuData[4:0];
            if (iCpuAddr[14:13] == 2'd2) rom_hi_d = iCpuData[1:0];
            if (iCpuAddr[14:13] == 2'd3) mode_d = iCpuData[0];
        end
        if (cpu_wr && is_ff50 && iCpuData != 8'h00) bios_off_d = 1'b1;
        if (run) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = cnt_q == LEN ? IDLE : RUN;
        end
        // A restart keeps wr_d so the read already issued still lands in OAM.
        if (cpu_wr && is_ff46) begin
            dma_src_d = iCpuData;
            cnt_d     = 8'd0;
            state_d   = RUN;
        end
        if (iCpuReadRequest) begin
            if (is_hram) rd_val_d = hram_q[iCpuAddr[6:0]];
            else if (run) rd_val_d = 8'hFF;
            else if (is_ff50) rd_val_d = {7'h7F, bios_off_q};
            else if (is_ff46) rd_val_d = dma_src_q;
            else if ((is_ext && !ram_en_q) || blocked) rd_val_d = 8'hFF;
            else rd_bus_d = 1'b1;
        end
    end
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= IDLE;
            rom_lo_q   <= 5'd1;
            rom_hi_q   <= 2'd0;
            mode_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            bios_off_q <= 1'b0;
            dma_src_q  <= 8'h00;
            cnt_q      <= 8'h00;
            wr_q       <= 1'b0;
            wr_idx_q   <= 8'h00;
            rd_bus_q   <= 1'b0;
            rd_val_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            rom_lo_q   <= rom_lo_d;
            rom_hi_q   <= rom_hi_d;
            mode_q     <= mode_d;
            ram_en_q   <= ram_en_d;
            bios_off_q <= bios_off_d;
            dma_src_q  <= dma_src_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            wr_idx_q   <= wr_idx_d;
            rd_bus_q   <= rd_bus_d;
            rd_val_q   <= rd_val_d;
        end
    end
    always_ff @(posedge iClock) begin
        if (cpu_wr && is_hram) hram_q[iCpuAddr[6:0]] <= iCpuData;
    end
endmodule

// File: tb/tb_mmu_banked.sv
// tb_mmu_banked: directed vectors for banking, BIOS unmap, locks, HRAM and OAM DMA.
module tb_mmu_banked;
    logic        iClock = 1'b0, iReset = 1'b1;
    logic [15:0] iCpuAddr = 16'h8000;
    logic        iCpuReadRequest = 1'b0, iCpuWe = 1'b0;
    logic [7:0]  iCpuData = 8'h00, iBusData = 8'h00;
    logic        iGpuVramLock = 1'b0, iGpuOamLock = 1'b0;
    logic [7:0]  oCpuData, oBusData, oOamAddr, oOamData;
    logic [15:0] oBusAddr;
    logic        oBusWe, oBiosSel, oExtRamWe, oOamWe, oDmaActive;
    logic [20:0] oRomAddr;
    logic [14:0] oExtRamAddr;
    int vecs = 0, errs = 0;

    mmu_banked dut (
        .iClock(iClock), .iReset(iReset), .iCpuAddr(iCpuAddr), .iCpuReadRequest(iCpuReadRequest),
        .iCpuWe(iCpuWe), .iCpuData(iCpuData), .oCpuData(oCpuData), .oBusAddr(oBusAddr),
        .oBusWe(oBusWe), .oBusData(oBusData), .iBusData(iBusData), .oRomAddr(oRomAddr),
        .oBiosSel(oBiosSel), .oExtRamAddr(oExtRamAddr), .oExtRamWe(oExtRamWe), .oOamWe(oOamWe),
        .oOamAddr(oOamAddr), .oOamData(oOamData), .oDmaActive(oDmaActive),
        .iGpuVramLock(iGpuVramLock), .iGpuOamLock(iGpuOamLock)
    );

    always #5 iClock = ~iClock;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous memory model: one cycle of read latency.
    always @(posedge iClock) iBusData <= mem_f(oBusAddr);

    task automatic tick;
        @(posedge iClock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        iCpuAddr = a; iCpuData = d; iCpuWe = 1'b1;
        tick();
        iCpuWe = 1'b0; iCpuAddr = 16'h8000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        iCpuAddr = a; iCpuReadRequest = 1'b1;
        tick();
        iCpuReadRequest = 1'b0; iCpuAddr = 16'h8000;
        d = oCpuData;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        repeat (2) @(posedge iClock);
        #1;
        vecs++; if (oCpuData !== 8'h00) begin errs++; $display("FAIL reset_cpudata got %h exp 00", oCpuData); end
        vecs++; if (oBusAddr !== 16'h8000) begin errs++; $display("FAIL reset_busaddr got %h exp 8000", oBusAddr); end
        vecs++; if (oRomAddr !== 21'h0) begin errs++; $display("FAIL reset_romaddr got %h exp 0", oRomAddr); end
        vecs++; if ({oBusWe, oBiosSel, oExtRamWe, oOamWe, oDmaActive} !== 5'b0) begin errs++; $display("FAIL reset_strobes got %b exp 00000", {oBusWe, oBiosSel, oExtRamWe, oOamWe, oDmaActive}); end
        vecs++; if ({oOamAddr, oOamData, oExtRamAddr} !== 31'h0) begin errs++; $display("FAIL reset_oam_ext got %h exp 0", {oOamAddr, oOamData, oExtRamAddr}); end
        iReset = 1'b0;
        rd(16'hFF50, d);
        vecs++; if (d !== 8'hFE) begin errs++; $display("FAIL reset_ff50 got %h exp FE", d); end
        iCpuAddr = 16'h4000; #1;
        vecs++; if (oRomAddr !== 21'h004000) begin errs++; $display("FAIL reset_bank1 got %h exp 004000", oRomAddr); end
        iCpuAddr = 16'h8000;
    endtask

    task automatic test_rom_bank;
        iCpuAddr = 16'h2000; iCpuData = 8'h00; iCpuWe = 1'b1; #1;
        vecs++; if (oBusWe !== 1'b0) begin errs++; $display("FAIL mbc_no_buswe got %b exp 0", oBusWe); end
        tick(); iCpuWe = 1'b0;
        iCpuAddr = 16'h4000; #1;
        vecs++; if (oRomAddr !== 21'h004000) begin errs++; $display("FAIL rom_zero_fix got %h exp 004000", oRomAddr); end
        wr(16'h2000, 8'h05);
        wr(16'h4000, 8'h02);
        iCpuAddr = 16'h4123; #1;
        vecs++; if (oRomAddr !== 21'h114123) begin errs++; $display("FAIL rom_bank45 got %h exp 114123", oRomAddr); end
        iCpuAddr = 16'h0123; #1;
        vecs++; if (oRomAddr !== 21'h000123) begin errs++; $display("FAIL rom_bank0 got %h exp 000123", oRomAddr); end
        wr(16'h2000, 8'h20);
        iCpuAddr = 16'h4000; #1;
        vecs++; if (oRomAddr !== 21'h104000) begin errs++; $display("FAIL rom_bank41 got %h exp 104000", oRomAddr); end
        iCpuAddr = 16'h8000;
    endtask

    task automatic test_ext_ram;
        logic [7:0] d;
        iCpuAddr = 16'hA000; iCpuData = 8'h55; iCpuWe = 1'b1; #1;
        vecs++; if (oExtRamWe !== 1'b0) begin errs++; $display("FAIL ext_we_disabled got %b exp 0", oExtRamWe); end
        vecs++; if (oBusWe !== 1'b0) begin errs++; $display("FAIL ext_no_buswe got %b exp 0", oBusWe); end
        tick(); iCpuWe = 1'b0;
        rd(16'hA000, d);
        vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL ext_rd_disabled got %h exp FF", d); end
        wr(16'h0000, 8'h0A);
        iCpuAddr = 16'hA010; #1;
        vecs++; if (oExtRamAddr !== 15'h0010) begin errs++; $display("FAIL ext_mode0 got %h exp 0010", oExtRamAddr); end
        wr(16'h6000, 8'h01);
        wr(16'h4000, 8'h03);
        iCpuAddr = 16'hA010; iCpuData = 8'h66; iCpuWe = 1'b1; #1;
        vecs++; if (oExtRamWe !== 1'b1) begin errs++; $display("FAIL ext_we_enabled got %b exp 1", oExtRamWe); end
        vecs++; if (oExtRamAddr !== 15'h6010) begin errs++; $display("FAIL ext_bank3 got %h exp 6010", oExtRamAddr); end
        tick(); iCpuWe = 1'b0;
        rd(16'hA010, d);
        vecs++; if (d !== 8'hEA) begin errs++; $display("FAIL ext_rd_enabled got %h exp EA", d); end
    endtask

    task automatic test_bios;
        logic [7:0] d;
        iCpuAddr = 16'h0050; #1;
        vecs++; if (oBiosSel !== 1'b1) begin errs++; $display("FAIL bios_on got %b exp 1", oBiosSel); end
        wr(16'hFF50, 8'h01);
        iCpuAddr = 16'h0050; #1;
        vecs++; if (oBiosSel !== 1'b0) begin errs++; $display("FAIL bios_off got %b exp 0", oBiosSel); end
        wr(16'hFF50, 8'h00);
        rd(16'hFF50, d);
        vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL bios_ff50 got %h exp FF", d); end
    endtask

    task automatic test_locks;
        logic [7:0] d;
        iGpuVramLock = 1'b1;
        iCpuAddr = 16'h8000; iCpuWe = 1'b1; #1;
        vecs++; if (oBusWe !== 1'b0) begin errs++; $display("FAIL vram_lock_we got %b exp 0", oBusWe); end
        tick(); iCpuWe = 1'b0;
        rd(16'h8123, d);
        vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL vram_lock_rd got %h exp FF", d); end
        iGpuVramLock = 1'b0;
        iCpuAddr = 16'h8000; iCpuWe = 1'b1; #1;
        vecs++; if (oBusWe !== 1'b1) begin errs++; $display("FAIL vram_open_we got %b exp 1", oBusWe); end
        tick(); iCpuWe = 1'b0;
        rd(16'h8123, d);
        vecs++; if (d !== 8'hF8) begin errs++; $display("FAIL vram_open_rd got %h exp F8", d); end
        iGpuOamLock = 1'b1;
        rd(16'hFE10, d);
        vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL oam_lock_rd got %h exp FF", d); end
        iCpuAddr = 16'hFE9F; iCpuWe = 1'b1; #1;
        vecs++; if (oBusWe !== 1'b0) begin errs++; $display("FAIL oam_lock_we got %b exp 0", oBusWe); end
        tick(); iCpuWe = 1'b0;
        rd(16'hFEA0, d);
        vecs++; if (d !== 8'h04) begin errs++; $display("FAIL oam_lock_edge got %h exp 04", d); end
        iGpuOamLock = 1'b0;
    endtask

    task automatic test_hram;
        logic [7:0] d;
        wr(16'hFF90, 8'h3C);
        wr(16'hFFFE, 8'hC7);
        rd(16'hFF90, d);
        vecs++; if (d !== 8'h3C) begin errs++; $display("FAIL hram_ff90 got %h exp 3C", d); end
        rd(16'hFFFE, d);
        vecs++; if (d !== 8'hC7) begin errs++; $display("FAIL hram_fffe got %h exp C7", d); end
    endtask

    task automatic test_dma;
        int active = 0;
        wr(16'hFF46, 8'hC1);
        for (int c = 0; c < 170; c++) begin
            iCpuAddr = 16'h8000; iCpuWe = 1'b0; iCpuReadRequest = 1'b0;
            if (c == 10) begin iCpuAddr = 16'hC000; iCpuReadRequest = 1'b1; end
            if (c == 20) begin iCpuAddr = 16'hFF90; iCpuData = 8'hA5; iCpuWe = 1'b1; end
            if (c == 21) begin iCpuAddr = 16'hFF90; iCpuReadRequest = 1'b1; end
            if (c == 30) begin iCpuAddr = 16'hC000; iCpuData = 8'h77; iCpuWe = 1'b1; end
            #1;
            if (c == 11) begin vecs++; if (oCpuData !== 8'hFF) begin errs++; $display("FAIL dma_cpu_rd got %h exp FF", oCpuData); end end
            if (c == 22) begin vecs++; if (oCpuData !== 8'hA5) begin errs++; $display("FAIL dma_hram_rd got %h exp A5", oCpuData); end end
            if (c == 30) begin vecs++; if (oBusWe !== 1'b0) begin errs++; $display("FAIL dma_cpu_we got %b exp 0", oBusWe); end end
            if (oDmaActive === 1'b1) active++;
            vecs++; if (oDmaActive !== (c <= 160)) begin errs++; $display("FAIL dma_active c=%0d got %b", c, oDmaActive); end
            vecs++; if (oOamWe !== (c >= 1 && c <= 160)) begin errs++; $display("FAIL dma_oamwe c=%0d got %b", c, oOamWe); end
            if (c >= 1 && c <= 160) begin
                vecs++; if (oOamAddr !== 8'(c - 1)) begin errs++; $display("FAIL dma_oamaddr c=%0d got %h exp %h", c, oOamAddr, 8'(c - 1)); end
                vecs++; if (oOamData !== mem_f(16'(16'hC100 + c - 1))) begin errs++; $display("FAIL dma_oamdata c=%0d got %h exp %h", c, oOamData, mem_f(16'(16'hC100 + c - 1))); end
            end
            if (c < 160) begin
                vecs++; if (oBusAddr !== 16'(16'hC100 + c)) begin errs++; $display("FAIL dma_busaddr c=%0d got %h exp %h", c, oBusAddr, 16'(16'hC100 + c)); end
            end
            tick();
        end
        iCpuAddr = 16'h8000; iCpuWe = 1'b0; iCpuReadRequest = 1'b0;
        vecs++; if (active != 161) begin errs++; $display("FAIL dma_length got %0d exp 161", active); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        int n = 0;
        wr(16'hFF46, 8'hC4);
        repeat (5) tick();
        iCpuAddr = 16'hFF46; iCpuData = 8'hC5; iCpuWe = 1'b1; #1;
        vecs++; if (oBusAddr !== 16'hC405) begin errs++; $display("FAIL b2b_pre_addr got %h exp C405", oBusAddr); end
        tick(); iCpuWe = 1'b0; iCpuAddr = 16'h8000; #1;
        vecs++; if ({oOamWe, oOamAddr} !== {1'b1, 8'h05}) begin errs++; $display("FAIL b2b_inflight got %b/%h exp 1/05", oOamWe, oOamAddr); end
        vecs++; if (oOamData !== mem_f(16'hC405)) begin errs++; $display("FAIL b2b_inflight_data got %h exp %h", oOamData, mem_f(16'hC405)); end
        vecs++; if (oBusAddr !== 16'hC500) begin errs++; $display("FAIL b2b_restart_addr got %h exp C500", oBusAddr); end
        tick();
        vecs++; if ({oOamWe, oOamAddr} !== {1'b1, 8'h00} || oOamData !== mem_f(16'hC500)) begin errs++; $display("FAIL b2b_first got %b/%h/%h exp 1/00/%h", oOamWe, oOamAddr, oOamData, mem_f(16'hC500)); end
        while (oDmaActive === 1'b1 && n < 200) begin tick(); n++; end
        vecs++; if (n != 160) begin errs++; $display("FAIL b2b_duration got %0d exp 160", n); end
        rd(16'hFF46, d);
        vecs++; if (d !== 8'hC5) begin errs++; $display("FAIL b2b_ff46 got %h exp C5", d); end
    endtask

    task automatic test_dma_reset;
        int n = 0;
        wr(16'hFF46, 8'hC2);
        repeat (81) tick();
        vecs++; if ({oOamWe, oOamAddr} !== {1'b1, 8'd80}) begin errs++; $display("FAIL rst_idx80 got %b/%h exp 1/50", oOamWe, oOamAddr); end
        iReset = 1'b1; #1;
        vecs++; if ({oDmaActive, oOamWe} !== 2'b00) begin errs++; $display("FAIL rst_abort got %b exp 00", {oDmaActive, oOamWe}); end
        tick(); iReset = 1'b0;
        iCpuAddr = 16'h0050; #1;
        vecs++; if (oBiosSel !== 1'b1) begin errs++; $display("FAIL rst_bios got %b exp 1", oBiosSel); end
        wr(16'hFF46, 8'hC3);
        vecs++; if ({oDmaActive, oOamWe} !== 2'b10 || oBusAddr !== 16'hC300) begin errs++; $display("FAIL rst_restart got %b/%h exp 10/C300", {oDmaActive, oOamWe}, oBusAddr); end
        tick();
        vecs++; if ({oOamWe, oOamAddr} !== {1'b1, 8'h00} || oOamData !== mem_f(16'hC300)) begin errs++; $display("FAIL rst_first got %b/%h/%h exp 1/00/%h", oOamWe, oOamAddr, oOamData, mem_f(16'hC300)); end
        while (oDmaActive === 1'b1 && n < 200) begin tick(); n++; end
        vecs++; if (oDmaActive !== 1'b0) begin errs++; $display("FAIL rst_dma_timeout got %b exp 0", oDmaActive); end
    endtask

    initial begin
        test_reset();
        test_rom_bank();
        test_ext_ram();
        test_bios();
        test_locks();
        test_hram();
        test_dma();
        test_back_to_back();
        test_dma_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
